// File: rtl/consmax_ctrl.sv
// Control front-end for a consmax unit: loads its two lookup tables, streams
// one vector through it and buffers the results in a small output FIFO.
module consmax_ctrl #(
  parameter int IDATA_BIT  = 8,
  parameter int ODATA_BIT  = 8,
  parameter int CDATA_BIT  = 8,
  parameter int LUT_DATA   = 16,
  parameter int LUT_ADDR   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  lut_load_req,
  input  logic                  lut_in_valid,
  output logic                  lut_in_ready,
  input  logic [LUT_DATA-1:0]   lut_in_data,
  input  logic                  cfg_start,
  input  logic [7:0]            cfg_len,
  input  logic [CDATA_BIT-1:0]  cfg_shift,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDATA_BIT-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ODATA_BIT-1:0]  out_data,
  output logic                  out_last,
  output logic [CDATA_BIT-1:0]  cm_shift,
  output logic [LUT_ADDR:0]     cm_lut_waddr,
  output logic                  cm_lut_wen,
  output logic [LUT_DATA-1:0]   cm_lut_wdata,
  output logic [IDATA_BIT-1:0]  cm_idata,
  output logic                  cm_idata_valid,
  input  logic [ODATA_BIT-1:0]  cm_odata,
  input  logic                  cm_odata_valid,
  output logic                  busy,
  output logic                  lut_loaded,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    LUT_LOAD,
    STREAM,
    DRAIN
  } state_t;

  localparam int LUT_WORDS = 2 * (1 << LUT_ADDR);
  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);

  state_t                 state_q;
  logic [8:0]             wrCnt_q;
  logic [8:0]             issued_q;
  logic [8:0]             popped_q;
  logic [8:0]             len_q;
  logic                   lutLoaded_q;
  logic [CDATA_BIT-1:0]   cmShift_q;
  logic                   lutWen_q;
  logic [LUT_ADDR:0]      lutWaddr_q;
  logic [LUT_DATA-1:0]    lutWdata_q;
  logic [IDATA_BIT-1:0]   idata_q;
  logic                   idataValid_q;
  logic                   done_q;
  logic                   err_q;

  logic [ODATA_BIT-1:0]   fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0]          wrPtr_q, wrPtr_d;
  logic [PW-1:0]          rdPtr_q, rdPtr_d;
  logic [CW-1:0]          fifoCnt_q, fifoCnt_d;

  logic                   lutAccept;
  logic                   inAccept;
  logic                   fifoFull;
  logic                   pop;
  logic                   pushOk;
  logic                   overflow;
  logic [8:0]             outstanding;

  // Outstanding elements bound how far the input may run ahead of the output,
  // which also guarantees the FIFO can never overflow during a normal vector.
  assign outstanding  = issued_q - popped_q;
  assign lut_in_ready = (state_q == LUT_LOAD);
  assign lutAccept    = lut_in_valid && lut_in_ready;
  assign in_ready     = (state_q == STREAM) && (issued_q < len_q) &&
                        (outstanding < 9'(FIFO_DEPTH));
  assign inAccept     = in_valid && in_ready;

  assign fifoFull  = (fifoCnt_q == CW'(FIFO_DEPTH));
  assign out_valid = (fifoCnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign pushOk    = cm_odata_valid && (!fifoFull || pop);
  assign overflow  = cm_odata_valid && !pushOk;
  assign out_data  = out_valid ? fifoMem_q[rdPtr_q] : '0;
  assign out_last  = out_valid && ((popped_q + 9'd1) == len_q);

  assign busy           = (state_q != IDLE);
  assign lut_loaded     = lutLoaded_q;
  assign cm_shift       = cmShift_q;
  assign cm_lut_wen     = lutWen_q;
  assign cm_lut_waddr   = lutWaddr_q;
  assign cm_lut_wdata   = lutWdata_q;
  assign cm_idata       = idata_q;
  assign cm_idata_valid = idataValid_q;
  assign done           = done_q;
  assign err            = err_q;

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    fifoCnt_d = fifoCnt_q;
    if (pushOk) begin
      wrPtr_d = (wrPtr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rdPtr_q + PW'(1);
    end
    case ({pushOk, pop})
      2'b10:   fifoCnt_d = fifoCnt_q + CW'(1);
      2'b01:   fifoCnt_d = fifoCnt_q - CW'(1);
      default: fifoCnt_d = fifoCnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fifoCnt_q <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      fifoCnt_q <= fifoCnt_d;
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoMem_q[wrPtr_q] <= cm_odata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wrCnt_q      <= '0;
      issued_q     <= '0;
      popped_q     <= '0;
      len_q        <= '0;
      lutLoaded_q  <= 1'b0;
      cmShift_q    <= '0;
      lutWen_q     <= 1'b0;
      lutWaddr_q   <= '0;
      lutWdata_q   <= '0;
      idata_q      <= '0;
      idataValid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      lutWen_q     <= 1'b0;
      idataValid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= overflow;
      if (pop) begin
        popped_q <= popped_q + 9'd1;
      end
      case (state_q)
        IDLE: begin
          if (lut_load_req) begin
            state_q     <= LUT_LOAD;
            lutLoaded_q <= 1'b0;
            wrCnt_q     <= '0;
          end else if (cfg_start) begin
            if (!lutLoaded_q || (cfg_len == '0)) begin
              err_q <= 1'b1;
            end else begin
              len_q     <= {1'b0, cfg_len};
              cmShift_q <= cfg_shift;
              issued_q  <= '0;
              popped_q  <= '0;
              state_q   <= STREAM;
            end
          end
        end
        LUT_LOAD: begin
          if (lutAccept) begin
            lutWen_q   <= 1'b1;
            lutWdata_q <= lut_in_data;
            lutWaddr_q <= wrCnt_q[LUT_ADDR:0];
            if (wrCnt_q == 9'(LUT_WORDS - 1)) begin
              wrCnt_q     <= '0;
              lutLoaded_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              wrCnt_q <= wrCnt_q + 9'd1;
            end
          end
        end
        STREAM: begin
          if (inAccept) begin
            idata_q      <= in_data;
            idataValid_q <= 1'b1;
            issued_q     <= issued_q + 9'd1;
            if ((issued_q + 9'd1) == len_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && ((popped_q + 9'd1) == len_q)) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_consmax_ctrl.sv
// Randomised bench for consmax_ctrl: a queue-based behavioural model is checked
// against the DUT every cycle, plus literal checks of the key scenarios.
module tb_consmax_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int LUT_WORDS  = 32;
  localparam int M_IDLE     = 0;
  localparam int M_LOAD     = 1;
  localparam int M_STREAM   = 2;
  localparam int M_DRAIN    = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        lut_load_req = 1'b0;
  logic        lut_in_valid = 1'b0;
  logic        lut_in_ready;
  logic [15:0] lut_in_data = '0;
  logic        cfg_start = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic [7:0]  cfg_shift = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic [7:0]  cm_shift;
  logic [4:0]  cm_lut_waddr;
  logic        cm_lut_wen;
  logic [15:0] cm_lut_wdata;
  logic [7:0]  cm_idata;
  logic        cm_idata_valid;
  logic [7:0]  cm_odata;
  logic        cm_odata_valid;
  logic        busy;
  logic        lut_loaded;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  consmax_ctrl dut (
    .clk(clk), .rstn(rstn),
    .lut_load_req(lut_load_req), .lut_in_valid(lut_in_valid),
    .lut_in_ready(lut_in_ready), .lut_in_data(lut_in_data),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .cm_shift(cm_shift), .cm_lut_waddr(cm_lut_waddr),
    .cm_lut_wen(cm_lut_wen), .cm_lut_wdata(cm_lut_wdata),
    .cm_idata(cm_idata), .cm_idata_valid(cm_idata_valid),
    .cm_odata(cm_odata), .cm_odata_valid(cm_odata_valid),
    .busy(busy), .lut_loaded(lut_loaded), .done(done), .err(err)
  );

  // Stand-in consmax unit: XORs each element with 0xA5, two cycles of latency.
  logic       stubEn = 1'b1;
  logic       manValid = 1'b0;
  logic [7:0] manData = '0;
  logic       st1V = 1'b0, st2V = 1'b0;
  logic [7:0] st1D = '0, st2D = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      st1V <= 1'b0;
      st2V <= 1'b0;
    end else begin
      st2V <= st1V;
      st2D <= st1D;
      st1V <= cm_idata_valid;
      st1D <= cm_idata;
    end
  end

  assign cm_odata_valid = stubEn ? st2V : manValid;
  assign cm_odata       = stubEn ? (st2D ^ 8'hA5) : manData;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, counters and a queue standing in for the FIFO.
  int         mMode = M_IDLE;
  bit         mLoaded = 0;
  int         mWords = 0;
  int         mLen = 0;
  logic [7:0] mShift = '0;
  int         mIssued = 0;
  int         mPopped = 0;
  logic [7:0] mFifo[$];
  bit         eWen = 0, eIdataValid = 0, eDone = 0, eErr = 0;
  logic [4:0] eWaddr = '0;
  logic [15:0] eWdata = '0;
  logic [7:0] eIdata = '0;
  bit         mLutAcc, mInAcc, mPop, mFull;

  function automatic bit expInReady();
    return (mMode == M_STREAM) && (mIssued < mLen) && ((mIssued - mPopped) < FIFO_DEPTH);
  endfunction

  function automatic void modelReset();
    mMode = M_IDLE; mLoaded = 0; mWords = 0; mLen = 0; mShift = '0;
    mIssued = 0; mPopped = 0; mFifo.delete();
    eWen = 0; eIdataValid = 0; eDone = 0; eErr = 0;
    eWaddr = '0; eWdata = '0; eIdata = '0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      modelReset();
    end else begin
      mLutAcc = (mMode == M_LOAD) && lut_in_valid;
      mInAcc  = expInReady() && in_valid;
      mPop    = (mFifo.size() > 0) && out_ready;
      mFull   = (mFifo.size() >= FIFO_DEPTH);
      eWen = 0; eIdataValid = 0; eDone = 0; eErr = 0;
      if (mPop) begin
        mFifo.delete(0);
        mPopped++;
      end
      if (cm_odata_valid) begin
        if (!mFull || mPop) mFifo.push_back(cm_odata);
        else eErr = 1;
      end
      case (mMode)
        M_IDLE: begin
          if (lut_load_req) begin
            mMode = M_LOAD; mLoaded = 0; mWords = 0;
          end else if (cfg_start) begin
            if (!mLoaded || cfg_len == 0) eErr = 1;
            else begin
              mLen = cfg_len; mShift = cfg_shift; mIssued = 0; mPopped = 0;
              mMode = M_STREAM;
            end
          end
        end
        M_LOAD: begin
          if (mLutAcc) begin
            eWen = 1; eWdata = lut_in_data; eWaddr = 5'(mWords);
            mWords++;
            if (mWords == LUT_WORDS) begin
              mWords = 0; mLoaded = 1; mMode = M_IDLE;
            end
          end
        end
        M_STREAM: begin
          if (mInAcc) begin
            eIdataValid = 1; eIdata = in_data; mIssued++;
            if (mIssued == mLen) mMode = M_DRAIN;
          end
        end
        default: begin
          if (mPop && mPopped == mLen) begin
            eDone = 1; mMode = M_IDLE;
          end
        end
      endcase
    end
  end

  // Event logs from the DUT side, used by the literal scenario checks.
  int          errPulses = 0;
  int          donePulses = 0;
  int          acceptCnt = 0;
  logic [8:0]  popLog[$];
  logic [20:0] lutLog[$];

  always @(negedge clk) begin
    if (!rstn) begin
      checkOutput("rst_ctl", {busy, lut_loaded, done, err, in_ready, lut_in_ready,
                              out_valid, out_last, cm_lut_wen, cm_idata_valid}, 0);
      checkOutput("rst_data", {cm_shift, cm_lut_waddr, out_data, cm_idata}, 0);
      checkOutput("rst_wdata", cm_lut_wdata, 0);
    end else begin
      if (err) errPulses++;
      if (done) donePulses++;
      if (in_valid && in_ready) acceptCnt++;
      if (out_valid && out_ready) popLog.push_back({out_last, out_data});
      if (cm_lut_wen) lutLog.push_back({cm_lut_waddr, cm_lut_wdata});
      checkOutput("lut_in_ready", lut_in_ready, mMode == M_LOAD);
      checkOutput("in_ready", in_ready, expInReady());
      checkOutput("busy", busy, mMode != M_IDLE);
      checkOutput("lut_loaded", lut_loaded, mLoaded);
      checkOutput("cm_shift", cm_shift, mShift);
      checkOutput("cm_lut_wen", cm_lut_wen, eWen);
      checkOutput("cm_idata_valid", cm_idata_valid, eIdataValid);
      checkOutput("done", done, eDone);
      checkOutput("err", err, eErr);
      checkOutput("out_valid", out_valid, mFifo.size() > 0);
      checkOutput("out_last", out_last, (mFifo.size() > 0) && (mPopped + 1 == mLen));
      if (mFifo.size() > 0) checkOutput("out_data", out_data, mFifo[0]);
      if (eWen) begin
        checkOutput("cm_lut_waddr", cm_lut_waddr, eWaddr);
        checkOutput("cm_lut_wdata", cm_lut_wdata, eWdata);
      end
      if (eIdataValid) checkOutput("cm_idata", cm_idata, eIdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startVector(input int len, input logic [7:0] shift);
    cfg_start = 1'b1;
    cfg_len   = 8'(len);
    cfg_shift = shift;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic loadLut(input logic [15:0] base, input bit sendReq);
    int cyc;
    lutLog.delete();
    if (sendReq) begin
      lut_load_req = 1'b1;
      tick();
      lut_load_req = 1'b0;
    end
    cyc = 0;
    while (lutLog.size() < LUT_WORDS && cyc < 300) begin
      lut_in_valid = ($urandom_range(0, 2) != 0);
      lut_in_data  = 16'(base + 16'(mWords));
      tick();
      cyc++;
    end
    lut_in_valid = 1'b0;
    tick();
    checkOutput("lut_words", lutLog.size(), LUT_WORDS);
    for (int i = 0; i < lutLog.size() && i < LUT_WORDS; i++) begin
      checkOutput("lut_entry", lutLog[i], {5'(i), 16'(base + 16'(i))});
    end
    checkOutput("lut_loaded_after", lut_loaded, 1);
    checkOutput("lut_busy_after", busy, 0);
  endtask

  task automatic runVector(input int len, input logic [7:0] shift, input int readyPct,
                           input int holdCycles, input int base);
    int d0, e0, cyc;
    d0 = donePulses;
    e0 = errPulses;
    popLog.delete();
    acceptCnt = 0;
    startVector(len, shift);
    for (int i = 0; i < holdCycles; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'(base + 7 * mIssued);
      out_ready = 1'b0;
      tick();
    end
    if (holdCycles > 0) begin
      checkOutput("hold_issued", acceptCnt, 4);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_err", errPulses - e0, 0);
    end
    cyc = 0;
    while (donePulses == d0 && cyc < 20 * len + 100) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_data      = 8'(base + 7 * mIssued);
      out_ready    = ($urandom_range(0, 99) < readyPct);
      cfg_start    = (mMode == M_STREAM) && ($urandom_range(0, 15) == 0);
      lut_load_req = (mMode == M_STREAM) && ($urandom_range(0, 15) == 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0; cfg_start = 1'b0; lut_load_req = 1'b0; out_ready = 1'b1;
    tick();
    checkOutput("vec_done", donePulses - d0, 1);
    checkOutput("vec_err", errPulses - e0, 0);
    checkOutput("vec_count", popLog.size(), len);
    checkOutput("vec_shift", cm_shift, shift);
    checkOutput("vec_busy", busy, 0);
    for (int i = 0; i < popLog.size() && i < len; i++) begin
      checkOutput("vec_data", popLog[i][7:0], 8'(base + 7 * i) ^ 8'hA5);
      checkOutput("vec_last", popLog[i][8], i == len - 1);
    end
  endtask

  task automatic applyStimulus();
    int e0, cyc;
    logic [7:0] sh;
    #1 rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Vector request with no table loaded
    e0 = errPulses;
    startVector(4, 8'h11);
    tick(); tick();
    checkOutput("nolut_err", errPulses - e0, 1);
    checkOutput("nolut_busy", busy, 0);

    loadLut(16'h0000, 1'b1);
    runVector(8, 8'h05, 100, 0, 8'h10);
    runVector(10, 8'h3C, 100, 20, 8'h40);

    // Simultaneous load and start requests: load wins, start is dropped
    e0 = errPulses;
    lut_load_req = 1'b1; cfg_start = 1'b1; cfg_len = 8'd5; cfg_shift = 8'h77;
    tick();
    lut_load_req = 1'b0; cfg_start = 1'b0;
    checkOutput("both_lut_ready", lut_in_ready, 1);
    checkOutput("both_loaded_clr", lut_loaded, 0);
    checkOutput("both_shift", cm_shift, 8'h3C);
    tick();
    checkOutput("both_err", errPulses - e0, 0);
    loadLut(16'h0100, 1'b0);

    e0 = errPulses;
    startVector(0, 8'h01);
    tick(); tick();
    checkOutput("len0_err", errPulses - e0, 1);
    checkOutput("len0_busy", busy, 0);

    for (int v = 0; v < 6; v++) begin
      sh = 8'($urandom);
      runVector($urandom_range(1, 12), sh, $urandom_range(30, 100), 0, $urandom_range(0, 255));
    end
    runVector(255, 8'hC3, 80, 0, 8'h21);

    // Overflow: six pushes into a four-entry FIFO, then push and pop while full
    stubEn = 1'b0;
    popLog.delete();
    e0 = errPulses;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      manValid = 1'b1; manData = 8'(i);
      tick();
    end
    manValid = 1'b1; manData = 8'h40; out_ready = 1'b1;
    tick();
    manValid = 1'b0;
    repeat (6) tick();
    checkOutput("ovf_err", errPulses - e0, 2);
    checkOutput("ovf_count", popLog.size(), 5);
    for (int i = 0; i < popLog.size() && i < 5; i++) begin
      checkOutput("ovf_data", popLog[i][7:0], (i == 4) ? 8'h40 : 8'(i));
    end
    stubEn = 1'b1;

    // Reset in the middle of a vector
    acceptCnt = 0;
    startVector(8, 8'h33);
    in_valid = 1'b1; out_ready = 1'b0;
    cyc = 0;
    while (acceptCnt < 3 && cyc < 20) begin
      in_data = 8'($urandom);
      tick();
      cyc++;
    end
    checkOutput("midrst_issued", acceptCnt, 3);
    rstn = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    checkOutput("midrst_loaded", lut_loaded, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_shift", cm_shift, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    rstn = 1'b1;
    tick();
    e0 = errPulses;
    startVector(4, 8'h01);
    tick(); tick();
    checkOutput("midrst_reject", errPulses - e0, 1);
    checkOutput("midrst_reject_busy", busy, 0);
    loadLut(16'h0055, 1'b1);
    runVector(5, 8'h09, 80, 0, 8'h90);
  endtask

  initial begin
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
